// File: rtl/vga_scanout.sv
// VGA scan-out back end: programmable timing generator, pausable frame counter and
// 8x8 ordered-dither quantiser, with sync and colour registered together onto the pins.
module vga_scanout #(
    parameter int H_DISPLAY       = 1220,
    parameter int H_FRONT_PORCH   = 31,
    parameter int H_SYNC_PULSE    = 183,
    parameter int H_BACK_PORCH    = 91,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_PULSE    = 2,
    parameter int V_BACK_PORCH    = 33,
    parameter int HSYNC_NEG       = 1,
    parameter int VSYNC_NEG       = 1,
    parameter int IN_BITS         = 6,
    parameter int OUT_BITS        = 2,
    parameter int FRAME_BITS      = 11,
    parameter int DITHER_TEMPORAL = 1
) (
    input  logic                  clk48,
    input  logic                  rst_n,
    input  logic                  pause_n,
    input  logic [IN_BITS-1:0]    pix_r,
    input  logic [IN_BITS-1:0]    pix_g,
    input  logic [IN_BITS-1:0]    pix_b,
    output logic [10:0]           h_count,
    output logic [9:0]            v_count,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  display_active,
    output logic                  line_start,
    output logic                  frame_start,
    output logic                  hsync,
    output logic                  vsync,
    output logic [OUT_BITS-1:0]   r_out,
    output logic [OUT_BITS-1:0]   g_out,
    output logic [OUT_BITS-1:0]   b_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int S       = IN_BITS - OUT_BITS;
    localparam int T_SHIFT = 6 - S;

    if (S < 1 || S > 6) begin : g_bad_depth
        $error("vga_scanout: IN_BITS-OUT_BITS must lie in 1..6");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_scanout: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
    end

    // One extra bit on the comparison constants so a window ending exactly at 2048/1024 still fits
    localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_END    = 12'(H_DISPLAY);
    localparam logic [11:0] H_SYNC_START = 12'(H_DISPLAY + H_FRONT_PORCH);
    localparam logic [11:0] H_SYNC_END   = 12'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_END    = 11'(V_DISPLAY);
    localparam logic [10:0] V_SYNC_START = 11'(V_DISPLAY + V_FRONT_PORCH);
    localparam logic [10:0] V_SYNC_END   = 11'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic        HS_IDLE      = (HSYNC_NEG != 0);
    localparam logic        VS_IDLE      = (VSYNC_NEG != 0);
    localparam logic        TEMPORAL_EN  = (DITHER_TEMPORAL != 0);

    logic [10:0]           r_hCount;
    logic [9:0]            r_vCount;
    logic [FRAME_BITS-1:0] r_frame;
    logic                  r_hsync;
    logic                  r_vsync;
    logic [OUT_BITS-1:0]   r_rOut;
    logic [OUT_BITS-1:0]   r_gOut;
    logic [OUT_BITS-1:0]   r_bOut;

    logic [11:0] w_hExt;
    logic [10:0] w_vExt;
    logic        w_hLast;
    logic        w_vLast;
    logic        w_active;
    logic        w_hsyncAct;
    logic        w_vsyncAct;
    logic [2:0]  w_ditherI;
    logic [2:0]  w_ditherJ;
    logic [5:0]  w_m6;
    logic [5:0]  w_thr;

    assign w_hExt     = {1'b0, r_hCount};
    assign w_vExt     = {1'b0, r_vCount};
    assign w_hLast    = (w_hExt == H_LAST);
    assign w_vLast    = (w_vExt == V_LAST);
    assign w_active   = (w_hExt < H_ACT_END) && (w_vExt < V_ACT_END);
    assign w_hsyncAct = (w_hExt >= H_SYNC_START) && (w_hExt < H_SYNC_END);
    assign w_vsyncAct = (w_vExt >= V_SYNC_START) && (w_vExt < V_SYNC_END);

    // Bayer index: bit-reversed interleave of column/row bits gives the 0..63 threshold
    assign w_ditherI = r_hCount[2:0] ^ {2'b00, r_frame[0] & TEMPORAL_EN};
    assign w_ditherJ = r_vCount[2:0];
    assign w_m6      = {w_ditherI[0] ^ w_ditherJ[0], w_ditherI[0],
                        w_ditherI[1] ^ w_ditherJ[1], w_ditherI[1],
                        w_ditherI[2] ^ w_ditherJ[2], w_ditherI[2]};
    assign w_thr     = w_m6 >> T_SHIFT;

    // Sum carries one spare bit so a bright pixel saturates instead of wrapping to black
    function automatic logic [OUT_BITS-1:0] quantise(input logic [IN_BITS-1:0] pix,
                                                     input logic [5:0] thr);
        logic [IN_BITS:0] sum;
        logic [IN_BITS:0] shifted;
        sum     = {1'b0, pix} + (IN_BITS+1)'(thr);
        shifted = sum >> S;
        if (|shifted[IN_BITS:OUT_BITS]) begin
            return {OUT_BITS{1'b1}};
        end
        return shifted[OUT_BITS-1:0];
    endfunction

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_hCount <= '0;
            r_vCount <= '0;
            r_frame  <= '0;
        end else if (w_hLast) begin
            r_hCount <= '0;
            if (w_vLast) begin
                r_vCount <= '0;
                if (pause_n) begin
                    r_frame <= r_frame + 1'b1;
                end
            end else begin
                r_vCount <= r_vCount + 1'b1;
            end
        end else begin
            r_hCount <= r_hCount + 1'b1;
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= HS_IDLE;
            r_vsync <= VS_IDLE;
            r_rOut  <= '0;
            r_gOut  <= '0;
            r_bOut  <= '0;
        end else begin
            r_hsync <= w_hsyncAct ^ HS_IDLE;
            r_vsync <= w_vsyncAct ^ VS_IDLE;
            r_rOut  <= w_active ? quantise(pix_r, w_thr) : '0;
            r_gOut  <= w_active ? quantise(pix_g, w_thr) : '0;
            r_bOut  <= w_active ? quantise(pix_b, w_thr) : '0;
        end
    end

    assign h_count        = r_hCount;
    assign v_count        = r_vCount;
    assign frame          = r_frame;
    assign display_active = w_active;
    assign line_start     = (r_hCount == 11'd0);
    assign frame_start    = (r_hCount == 11'd0) && (r_vCount == 10'd0);
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign r_out          = r_rOut;
    assign g_out          = r_gOut;
    assign b_out          = r_bOut;

endmodule
